snax_tcdm_responder: RTL and testbench



---
 rtl/snax_tcdm_resp_pkg.sv | 43 ++++
 rtl/snax_rr_arbiter.sv | 31 +++
 rtl/snax_tcdm_responder.sv | 81 ++++++++
 tb/tb_snax_tcdm_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/snax_tcdm_resp_pkg.sv
// snax_tcdm_resp_pkg: shared TCDM types, AMO codes, LFSR constants and word-index helper.
package snax_tcdm_resp_pkg;
  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;
  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Taps 8,6,5,4 mapped onto bits 7,5,4,3.
  localparam logic [7:0] LfsrTaps = 8'hB8;
  typedef struct packed {
    logic        write;
    logic [47:0] addr;
    amo_op_e     amo;
    logic [63:0] data;
    logic [0:0]  user;
    logic [7:0]  strb;
  } tcdm_req_chan_t;
  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;
  typedef struct packed {
    logic [63:0] data;
  } tcdm_rsp_chan_t;
  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;
  function automatic logic [31:0] idx_of(input logic [63:0] addr, input int lsb, input int width);
    return 32'((addr >> lsb) & ((64'd1 << width) - 64'd1));
  endfunction
endpackage

// File: rtl/snax_rr_arbiter.sv
// snax_rr_arbiter: one-hot round-robin arbiter, pointer advances past each granted port.
module snax_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr;
  // Scan from farthest to nearest so the port closest to ptr is the last (winning) assignment.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (en && req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk_i)
    if (rst_i) ptr <= '0;
    else if (|gnt) ptr <= gnt_idx == IW'(N - 1) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/snax_tcdm_responder.sv
// snax_tcdm_responder: single-bank TCDM memory with round-robin port arbitration and 1-cycle read latency.
// Optional random back-pressure LFSR enabled by defining SNAX_TCDM_RESP_STALL_EN.
module snax_tcdm_responder
  import snax_tcdm_resp_pkg::*;
#(
  parameter int  NumPorts      = 4,
  parameter int  DataWidth     = 64,
  parameter int  TCDMAddrWidth = 48,
  parameter int  Depth         = 64,
  parameter int  AddrLsb       = 0,
  parameter type tcdm_req_t    = snax_tcdm_resp_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t    = snax_tcdm_resp_pkg::tcdm_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  tcdm_req_t [NumPorts-1:0] tcdm_req_i,
  output tcdm_rsp_t [NumPorts-1:0] tcdm_rsp_o
);
  localparam int IdxW  = $clog2(Depth);
  localparam int StrbW = DataWidth / 8;
  localparam int PW    = $clog2(NumPorts);
  logic [DataWidth-1:0] mem [Depth];
  logic [NumPorts-1:0]  req, gnt;
  logic [PW-1:0]        gnt_idx, resp_port;
  logic                 en, gnt_any, p_valid_q;
  logic [IdxW-1:0]      idx;
  logic [DataWidth-1:0] rdata;
  tcdm_req_t            sel;
  logic                 unused_req;
  assign unused_req = ^tcdm_req_i;
  for (genvar i = 0; i < NumPorts; i++) begin : g_req
    assign req[i] = tcdm_req_i[i].q_valid;
  end
`ifdef SNAX_TCDM_RESP_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk_i)
    if (rst_i) lfsr <= LfsrSeed;
    else lfsr <= {lfsr[6:0], ^(lfsr & LfsrTaps)};
  assign en = ~lfsr[0];
`else
  assign en = 1'b1;
`endif
  snax_rr_arbiter #(.N(NumPorts)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  assign gnt_any = |gnt;
  assign sel = tcdm_req_i[gnt_idx];
  assign idx = IdxW'(idx_of(64'(TCDMAddrWidth'(sel.q.addr)), AddrLsb, IdxW));
  // Contents are deliberately not reset; a grant coinciding with reset is dropped.
  always_ff @(posedge clk_i)
    if (!rst_i && gnt_any && sel.q.write)
      for (int b = 0; b < StrbW; b++)
        if (sel.q.strb[b]) mem[idx][8*b +: 8] <= sel.q.data[8*b +: 8];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      p_valid_q <= 1'b0;
      resp_port <= '0;
      rdata <= '0;
    end else begin
      p_valid_q <= gnt_any;
      if (gnt_any) begin
        resp_port <= gnt_idx;
        rdata <= sel.q.write ? '0 : mem[idx];
      end
    end
  for (genvar i = 0; i < NumPorts; i++) begin : g_rsp
    assign tcdm_rsp_o[i].q_ready = gnt[i];
    assign tcdm_rsp_o[i].p_valid = p_valid_q && resp_port == PW'(i);
    assign tcdm_rsp_o[i].p.data = rdata;
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (!rst_i && gnt_any)
      assert (sel.q.amo == AMONone) else $error("snax_tcdm_responder: non-AMONone amo executed as plain access");
`endif
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// tb_snax_tcdm_responder: directed plus randomized bench against a behavioural memory/arbiter model.
module tb_snax_tcdm_responder;
  import snax_tcdm_resp_pkg::*;
  localparam int N = 4;
  localparam int D = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  tcdm_req_t [N-1:0] req;
  tcdm_rsp_t [N-1:0] rsp;
  int total = 0;
  int bad = 0;
  logic [63:0] mm [D];
  int ptr = 0;
  logic [7:0] lf = 8'hA5;
  int last_g = -1;
  int pv_cnt [N];
  always #5 clk = ~clk;
  snax_tcdm_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tcdm_req_i (req),
    .tcdm_rsp_o (rsp)
  );
  function automatic bit stalled();
`ifdef SNAX_TCDM_RESP_STALL_EN
    return lf[0];
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set(input int p, input bit v, input bit w, input logic [47:0] a,
                     input logic [63:0] d, input logic [7:0] s);
    req[p].q_valid = v;
    req[p].q.write = w;
    req[p].q.addr = a;
    req[p].q.data = d;
    req[p].q.strb = s;
    req[p].q.amo = AMONone;
    req[p].q.user = 1'($urandom);
  endtask
  // One clock: check combinational grant, advance the model, check the registered response.
  task automatic step(input bit r);
    int g, ix;
    logic [N-1:0] eq, oq, ev, ov;
    logic [63:0] ed;
    rst = r;
    #1;
    g = -1;
    if (!stalled())
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(ptr + k) % N].q_valid) g = (ptr + k) % N;
    eq = '0;
    if (g >= 0) eq[g] = 1'b1;
    for (int i = 0; i < N; i++) oq[i] = rsp[i].q_ready;
    if (!r) chk("q_ready", 64'(oq), 64'(eq));
    ev = '0;
    ed = '0;
    if (r) begin
      ptr = 0;
      g = -1;
    end else if (g >= 0) begin
      ix = int'(req[g].q.addr % 48'(D));
      if (req[g].q.write) begin
        for (int b = 0; b < 8; b++)
          if (req[g].q.strb[b]) mm[ix][8*b +: 8] = req[g].q.data[8*b +: 8];
      end else ed = mm[ix];
      ev[g] = 1'b1;
      ptr = (g + 1) % N;
    end
    last_g = g;
    lf = r ? 8'hA5 : {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) ov[i] = rsp[i].p_valid;
    chk("p_valid", 64'(ov), 64'(ev));
    if (g >= 0) chk("p_data", rsp[g].p.data, ed);
    if (r) chk("rst_p_data", rsp[0].p.data, 64'd0);
    for (int i = 0; i < N; i++) if (ov[i]) pv_cnt[i]++;
    @(negedge clk);
  endtask
  task automatic xfer(input int p, input bit w, input logic [47:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    bit done;
    done = 1'b0;
    set(p, 1'b1, w, a, d, s);
    for (int c = 0; c < 20 && !done; c++) begin
      step(1'b0);
      done = last_g == p;
    end
    if (!done) chk("xfer_timeout", 64'd0, 64'd1);
    req[p].q_valid = 1'b0;
  endtask
  initial begin
    int n;
    req = '0;
    for (int i = 0; i < N; i++) pv_cnt[i] = 0;
    @(negedge clk);
    set(0, 1'b1, 1'b0, 48'd0, 64'd0, 8'h00);
    step(1'b1);
    step(1'b1);
    req = '0;
    for (int i = 0; i < D; i++) xfer(i % N, 1'b1, 48'(i), {$urandom, $urandom}, 8'hFF);
    set(0, 1'b1, 1'b1, 48'd9, 64'hBAD, 8'hFF);
    step(1'b1);
    step(1'b1);
    req = '0;
    xfer(2, 1'b0, 48'd9, 64'd0, 8'h00);
    xfer(0, 1'b1, 48'd5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    xfer(0, 1'b0, 48'd5, 64'd0, 8'h00);
    chk("read_back_idx5", rsp[0].p.data, 64'hDEAD_BEEF_0123_4567);
    xfer(1, 1'b1, 48'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    xfer(1, 1'b1, 48'd3, 64'd0, 8'h0F);
    xfer(1, 1'b0, 48'd3, 64'd0, 8'h00);
    chk("strb_merge", rsp[1].p.data, 64'hFFFF_FFFF_0000_0000);
    xfer(2, 1'b1, 48'd3, 64'h1234, 8'h00);
    chk("wr_rsp_zero", rsp[2].p.data, 64'd0);
    xfer(3, 1'b0, 48'd3, 64'd0, 8'h00);
    chk("strb_zero_noop", rsp[3].p.data, 64'hFFFF_FFFF_0000_0000);
    xfer(0, 1'b1, 48'd1, 64'h11, 8'hFF);
    xfer(3, 1'b0, 48'd65, 64'd0, 8'h00);
    chk("alias_65", rsp[3].p.data, 64'h11);
    xfer(0, 1'b1, 48'd7, 64'hCAFE_F00D, 8'hFF);
    xfer(0, 1'b0, 48'd7, 64'd0, 8'h00);
    chk("raw_idx7", rsp[0].p.data, 64'hCAFE_F00D);
    step(1'b1);
    for (int i = 0; i < N; i++) pv_cnt[i] = 0;
    for (int i = 0; i < N; i++) set(i, 1'b1, 1'b0, 48'(i), 64'd0, 8'h00);
    for (int c = 0; c < 16; c++) step(1'b0);
`ifndef SNAX_TCDM_RESP_STALL_EN
    for (int i = 0; i < N; i++) chk("contention_cnt", 64'(pv_cnt[i]), 64'd4);
`endif
    req = '0;
    set(1, 1'b1, 1'b0, 48'd3, 64'd0, 8'h00);
    step(1'b1);
    req = '0;
    step(1'b0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set(i, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 48'({$urandom, $urandom}),
            {$urandom, $urandom}, 8'($urandom));
      step($urandom_range(0, 49) == 0);
    end
    req = '0;
`ifdef SNAX_TCDM_RESP_STALL_EN
    step(1'b1);
    pv_cnt[0] = 0;
    n = 0;
    for (int c = 0; c < 1000 && n < 100; c++) begin
      set(0, 1'b1, 1'b0, 48'(n), 64'd0, 8'h00);
      step(1'b0);
      if (last_g == 0) n++;
    end
    req = '0;
    chk("stall_pv_cnt", 64'(pv_cnt[0]), 64'd100);
`else
    n = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
